// File: rtl/sha256_message_schedule_if.sv
// Block-in / round-word-out bus of the SHA-256 message schedule.
// The scheduler is the slave; whoever feeds blocks and drains rounds is the master.
interface sha256_message_schedule_if;
   logic         block_valid;
   logic [511:0] block_data;
   logic         block_ready;
   logic         abort;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [31:0]  k_out;
   logic [5:0]   round_idx;
   logic         w_last;

   modport master (
      output block_valid, block_data, abort, w_ready,
      input  block_ready, w_valid, w_data, k_out, round_idx, w_last
   );

   modport slave (
      input  block_valid, block_data, abort, w_ready,
      output block_ready, w_valid, w_data, k_out, round_idx, w_last
   );
endinterface

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] with K[t], one round per handshake.
// Define SHA256_SCHED_CSA_EN to build the window update sum as two 3:2 carry-save stages plus one adder.
module sha256_message_schedule #(
   parameter int ROUNDS = 64
) (
   input  logic                      clk,
   input  logic                      reset_n,
   sha256_message_schedule_if.slave  bus
);

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

   state_t      state_q;
   logic [5:0]  round_q;
   logic [31:0] win [16];
   logic        vld_q;
   logic        last_q;
   logic        rdy_q;
   logic [31:0] w_next;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] sum4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
`ifdef SHA256_SCHED_CSA_EN
      logic [31:0] s1, m1, c1, s2, m2, c2;
      s1 = a ^ b ^ c;
      m1 = (a & b) | (a & c) | (b & c);
      c1 = {m1[30:0], 1'b0};
      s2 = s1 ^ c1 ^ d;
      m2 = (s1 & c1) | (s1 & d) | (c1 & d);
      c2 = {m2[30:0], 1'b0};
      return s2 + c2;
`else
      return ((a + b) + c) + d;
`endif
   endfunction

   assign w_next = sum4(sigma1(win[14]), win[9], sigma0(win[1]), win[0]);

   assign bus.block_ready = rdy_q;
   assign bus.w_valid     = vld_q;
   assign bus.w_last      = last_q;
   assign bus.round_idx   = round_q;
   assign bus.w_data      = win[0];
   assign bus.k_out       = K_ROM[round_q];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         round_q <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         rdy_q   <= 1'b0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               rdy_q <= 1'b1;
               // abort vetoes acceptance; otherwise it has nothing to cancel here
               if (bus.block_valid && rdy_q && !bus.abort) begin
                  for (int i = 0; i < 16; i++) win[i] <= bus.block_data[511 - 32*i -: 32];
                  round_q <= '0;
                  state_q <= RUN;
                  rdy_q   <= 1'b0;
                  vld_q   <= 1'b1;
                  last_q  <= (LAST_T == 6'd0);
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state_q <= IDLE;
                  round_q <= '0;
                  vld_q   <= 1'b0;
                  last_q  <= 1'b0;
                  rdy_q   <= 1'b1;
               end else if (bus.w_ready) begin
                  for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
                  win[15] <= w_next;
                  if (round_q == LAST_T) begin
                     state_q <= IDLE;
                     round_q <= '0;
                     vld_q   <= 1'b0;
                     last_q  <= 1'b0;
                     rdy_q   <= 1'b1;
                  end else begin
                     round_q <= round_q + 6'd1;
                     last_q  <= (round_q + 6'd1 == LAST_T);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Self-checking bench for sha256_message_schedule against a FIPS 180-4 style W[t] recurrence model.
module tb_sha256_message_schedule;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sha256_message_schedule_if bus ();

   sha256_message_schedule #(.ROUNDS(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   localparam logic [31:0] KTAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'd0, 32'h00000018};

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_w [64];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
   function automatic void build_model(input logic [511:0] blk);
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
         s1 = rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
         exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
      end
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
      return b;
   endfunction

   function automatic logic [71:0] obs();
      return {bus.w_valid, bus.w_last, bus.round_idx, bus.w_data, bus.k_out};
   endfunction

   function automatic logic [71:0] expect_round(input int t);
      return {1'b1, (t == 63), 6'(t), exp_w[t], KTAB[t]};
   endfunction

   // Presents a block at a falling edge and leaves it one edge after acceptance.
   task automatic offer(input logic [511:0] blk, input string name);
      int n = 0;
      bus.block_valid = 1'b1;
      bus.block_data  = blk;
      while (bus.block_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL %s_accept: block_ready never rose within 20 cycles, got %b want 1", name, bus.block_ready);
      end
      @(negedge clk);
      bus.block_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.w_valid, bus.w_last, bus.block_ready, bus.round_idx, bus.w_data} !== 41'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b l=%b rdy=%b t=%0d w=%h want all zero",
                  bus.w_valid, bus.w_last, bus.block_ready, bus.round_idx, bus.w_data);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.block_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", bus.block_ready, bus.w_valid);
      end
   endtask

   task automatic test_abc();
      int bad = 0;
      build_model(ABC_BLOCK);
      bus.w_ready = 1'b1;
      offer(ABC_BLOCK, "abc");
      for (int t = 0; t < 64; t++) begin
         if (t == 0 || t == 16 || t == 17 || t == 63) begin
            checks++;
            if ((t == 0  && {bus.w_data, bus.k_out} !== {32'h61626380, 32'h428a2f98}) ||
                (t == 16 && bus.w_data !== 32'h61626380) ||
                (t == 17 && bus.w_data !== 32'h000F0000) ||
                (t == 63 && {bus.k_out, bus.w_last} !== {32'hc67178f2, 1'b1})) begin
               errors++;
               $display("FAIL abc_known_t%0d: got w=%h k=%h last=%b", t, bus.w_data, bus.k_out, bus.w_last);
            end
         end
         checks++;
         if (obs() !== expect_round(t)) begin
            errors++;
            bad++;
            if (bad < 5) $display("FAIL abc_round: t=%0d got %h want %h", t, obs(), expect_round(t));
         end
         @(negedge clk);
      end
      checks++;
      if (bus.w_valid !== 1'b0 || bus.block_ready !== 1'b1) begin
         errors++;
         $display("FAIL abc_end: got v=%b rdy=%b want v=0 rdy=1", bus.w_valid, bus.block_ready);
      end
   endtask

   task automatic test_stall();
      int t = 0;
      build_model(ABC_BLOCK);
      bus.w_ready = 1'b0;
      offer(ABC_BLOCK, "stall");
      for (int cyc = 0; cyc < 128; cyc++) begin
         bus.w_ready = cyc[0];
         checks++;
         if (obs() !== expect_round(t)) begin
            errors++;
            $display("FAIL stall_round: cyc=%0d got %h want %h", cyc, obs(), expect_round(t));
         end
         @(negedge clk);
         if (cyc[0]) t++;
      end
      checks++;
      if (bus.w_valid !== 1'b0 || bus.block_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_end: after 128 cycles got v=%b rdy=%b want v=0 rdy=1", bus.w_valid, bus.block_ready);
      end
   endtask

   task automatic test_abort();
      logic [511:0] blk = rand_block();
      build_model(blk);
      bus.w_ready = 1'b1;
      offer(blk, "abort");
      for (int t = 0; t < 20; t++) @(negedge clk);
      checks++;
      if (obs() !== expect_round(20)) begin
         errors++;
         $display("FAIL abort_pre: got %h want %h", obs(), expect_round(20));
      end
      bus.abort = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.w_valid, bus.block_ready, bus.round_idx} !== {1'b0, 1'b1, 6'd0}) begin
         errors++;
         $display("FAIL abort_idle: got v=%b rdy=%b t=%0d want v=0 rdy=1 t=0", bus.w_valid, bus.block_ready, bus.round_idx);
      end
      // A block offered while abort is still high must be refused.
      bus.block_valid = 1'b1;
      bus.block_data  = blk;
      @(negedge clk);
      checks++;
      if (bus.w_valid !== 1'b0 || bus.block_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_refuse: got v=%b rdy=%b want v=0 rdy=1", bus.w_valid, bus.block_ready);
      end
      bus.abort = 1'b0;
      bus.block_valid = 1'b0;
      blk = rand_block();
      build_model(blk);
      offer(blk, "abort_restart");
      for (int t = 0; t < 64; t++) begin
         checks++;
         if (obs() !== expect_round(t)) begin
            errors++;
            $display("FAIL abort_restart: t=%0d got %h want %h", t, obs(), expect_round(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [511:0] blk = rand_block();
      build_model(blk);
      bus.w_ready = 1'b1;
      offer(blk, "rst_mid");
      for (int t = 0; t < 30; t++) @(negedge clk);
      checks++;
      if (bus.round_idx !== 6'd30) begin
         errors++;
         $display("FAIL rst_mid_pre: got t=%0d want 30", bus.round_idx);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.w_valid, bus.w_last, bus.block_ready, bus.round_idx, bus.w_data} !== 41'd0) begin
         errors++;
         $display("FAIL rst_mid_zero: got v=%b l=%b rdy=%b t=%0d w=%h want all zero",
                  bus.w_valid, bus.w_last, bus.block_ready, bus.round_idx, bus.w_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.block_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_release: got rdy=%b v=%b want rdy=1 v=0", bus.block_ready, bus.w_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.w_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_no_partial: got v=%b want 0", bus.w_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] blk_a = rand_block();
      logic [511:0] blk_b = rand_block();
      int n = 0;
      build_model(blk_a);
      bus.w_ready = 1'b1;
      bus.block_valid = 1'b1;
      bus.block_data  = blk_a;
      while (bus.block_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.block_data = blk_b;
      for (int t = 0; t < 64; t++) begin
         checks++;
         if (obs() !== expect_round(t) || bus.block_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: t=%0d got %h rdy=%b want %h rdy=0", t, obs(), bus.block_ready, expect_round(t));
         end
         @(negedge clk);
      end
      checks++;
      if (bus.w_valid !== 1'b0 || bus.block_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: got v=%b rdy=%b want v=0 rdy=1", bus.w_valid, bus.block_ready);
      end
      @(negedge clk);
      bus.block_valid = 1'b0;
      build_model(blk_b);
      for (int t = 0; t < 64; t++) begin
         checks++;
         if (obs() !== expect_round(t)) begin
            errors++;
            $display("FAIL b2b_second: t=%0d got %h want %h", t, obs(), expect_round(t));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 4; b++) begin
         logic [511:0] blk = rand_block();
         int t = 0;
         int cyc = 0;
         logic r;
         build_model(blk);
         offer(blk, "random");
         while (t < 64 && cyc < 1000) begin
            r = ($urandom_range(0, 3) != 0);
            bus.w_ready = r;
            checks++;
            if (obs() !== expect_round(t)) begin
               errors++;
               $display("FAIL random_round: blk=%0d t=%0d got %h want %h", b, t, obs(), expect_round(t));
            end
            @(negedge clk);
            if (r) t++;
            cyc++;
         end
         checks++;
         if (cyc >= 1000 || bus.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_end: blk=%0d cyc=%0d v=%b want completion with v=0", b, cyc, bus.w_valid);
         end
      end
   endtask

   initial begin
      bus.block_valid = 1'b0;
      bus.block_data  = '0;
      bus.abort       = 1'b0;
      bus.w_ready     = 1'b0;
      test_reset();
      test_abc();
      test_stall();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
